// File: rtl/switch_allocator.sv
// Separable-free switch allocator for a wormhole router: one IDLE/LOCKED FSM per output
// with round-robin head arbitration and combinational, zero-latency grants.
module switch_allocator #(
  parameter int NUM_PORTS = 5,
  parameter int PORT_W    = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        i_req,
  input  logic [NUM_PORTS-1:0]        i_head,
  input  logic [NUM_PORTS-1:0]        i_tail,
  input  logic [NUM_PORTS*PORT_W-1:0] i_dest,
  input  logic [NUM_PORTS-1:0]        i_out_on,
  output logic [NUM_PORTS-1:0]        o_grant,
  output logic [NUM_PORTS*PORT_W-1:0] o_sel,
  output logic [NUM_PORTS-1:0]        o_sel_valid,
  output logic [NUM_PORTS-1:0]        o_locked
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              r_state [NUM_PORTS];
  logic [PORT_W-1:0]   r_owner [NUM_PORTS];
  logic [PORT_W-1:0]   r_ptr   [NUM_PORTS];

  logic [PORT_W-1:0]   w_dest  [NUM_PORTS];
  logic [PORT_W-1:0]   w_win   [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_busy;
  logic [NUM_PORTS-1:0] w_gnt_out;
  logic [NUM_PORTS-1:0] w_head_gnt;
  logic [NUM_PORTS-1:0] w_win_tail;
  logic [NUM_PORTS-1:0] w_grant;

  // Cyclic first-hit search starting just after ptr; MSB of the result flags a hit.
  function automatic logic [PORT_W:0] rr_pick(input logic [NUM_PORTS-1:0] cand,
                                              input logic [PORT_W-1:0]    ptr);
    logic [PORT_W:0] res;
    int              idx;
    res = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(ptr) + k) % NUM_PORTS;
      if (!res[PORT_W] && cand[idx]) begin
        res = {1'b1, PORT_W'(idx)};
      end
    end
    return res;
  endfunction

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign w_dest[g]                 = i_dest[g*PORT_W +: PORT_W];
    assign o_sel[g*PORT_W +: PORT_W] = (w_gnt_out[g] && !reset) ? w_win[g] : '0;
    assign o_locked[g]               = (r_state[g] == ST_LOCKED) && !reset;
  end

  // An input that owns a locked output is mid-packet and cannot start another.
  always_comb begin
    w_busy = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (r_state[o] == ST_LOCKED && r_owner[o] == PORT_W'(i)) begin
          w_busy[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic [NUM_PORTS-1:0] w_cand;
    logic [PORT_W:0]      w_pick;
    w_gnt_out  = '0;
    w_head_gnt = '0;
    w_win_tail = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_win[o] = '0;
      w_cand   = '0;
      w_pick   = '0;
      if (r_state[o] == ST_IDLE) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          w_cand[i] = i_req[i] & i_head[i] & (w_dest[i] == PORT_W'(o)) & ~w_busy[i];
        end
        w_pick = rr_pick(w_cand, r_ptr[o]);
        if (w_pick[PORT_W] && i_out_on[o]) begin
          w_gnt_out[o]  = 1'b1;
          w_head_gnt[o] = 1'b1;
          w_win[o]      = w_pick[PORT_W-1:0];
        end
      end else begin
        // Locked: only the owner may move, whatever its head bit says.
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (r_owner[o] == PORT_W'(i) && i_req[i] &&
              w_dest[i] == PORT_W'(o) && i_out_on[o]) begin
            w_gnt_out[o] = 1'b1;
            w_win[o]     = PORT_W'(i);
          end
        end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_gnt_out[o] && w_win[o] == PORT_W'(i)) begin
          w_win_tail[o] = i_tail[i];
        end
      end
    end
  end

  always_comb begin
    w_grant = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_gnt_out[o] && w_win[o] == PORT_W'(i)) begin
          w_grant[i] = 1'b1;
        end
      end
    end
  end

  assign o_grant     = reset ? '0 : w_grant;
  assign o_sel_valid = reset ? '0 : w_gnt_out;

  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (reset) begin
        r_state[o] <= ST_IDLE;
        r_owner[o] <= '0;
        r_ptr[o]   <= PORT_W'(NUM_PORTS - 1);
      end else if (r_state[o] == ST_IDLE) begin
        if (w_head_gnt[o]) begin
          r_ptr[o] <= w_win[o];
          if (!w_win_tail[o]) begin
            r_state[o] <= ST_LOCKED;
            r_owner[o] <= w_win[o];
          end
        end
      end else if (w_gnt_out[o] && w_win_tail[o]) begin
        r_state[o] <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: per-cycle stimulus and expected outputs are queued,
// then applied and compared on the falling edge.
module tb_switch_allocator;
  localparam int NP = 5;
  localparam int PW = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [NP-1:0]      i_req, i_head, i_tail, i_out_on;
  logic [NP*PW-1:0]   i_dest;
  logic [NP-1:0]      o_grant, o_sel_valid, o_locked;
  logic [NP*PW-1:0]   o_sel;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic             rst;
    logic [NP-1:0]    req, head, tail, on;
    logic [NP*PW-1:0] dest;
    logic [NP-1:0]    grant, sv, lock;
    logic [NP*PW-1:0] sel;
  } vec_t;

  vec_t sb[$];

  switch_allocator #(.NUM_PORTS(NP), .PORT_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_head     (i_head),
    .i_tail     (i_tail),
    .i_dest     (i_dest),
    .i_out_on   (i_out_on),
    .o_grant    (o_grant),
    .o_sel      (o_sel),
    .o_sel_valid(o_sel_valid),
    .o_locked   (o_locked)
  );

  always #5 clk = ~clk;

  function automatic logic [NP*PW-1:0] pk(input int a0, input int a1, input int a2,
                                          input int a3, input int a4);
    return {PW'(a4), PW'(a3), PW'(a2), PW'(a1), PW'(a0)};
  endfunction

  task automatic push(input logic rst, input logic [NP-1:0] req, input logic [NP-1:0] head,
                      input logic [NP-1:0] tail, input logic [NP*PW-1:0] dest,
                      input logic [NP-1:0] on, input logic [NP-1:0] grant,
                      input logic [NP*PW-1:0] sel, input logic [NP-1:0] sv,
                      input logic [NP-1:0] lock);
    vec_t v;
    v.rst = rst; v.req = req; v.head = head; v.tail = tail; v.dest = dest; v.on = on;
    v.grant = grant; v.sel = sel; v.sv = sv; v.lock = lock;
    sb.push_back(v);
  endtask

  task automatic test_reset();
    vec_t v;
    int   cyc = 0;
    push(1'b1, 5'b00001, 5'b00001, 5'b00001, pk(0,0,0,0,0), 5'b11111, '0, '0, '0, '0);
    push(1'b0, '0, '0, '0, '0, 5'b11111, '0, '0, '0, '0);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      reset = v.rst; i_req = v.req; i_head = v.head; i_tail = v.tail; i_dest = v.dest; i_out_on = v.on;
      @(negedge clk);
      vectors++;
      if ({o_grant, o_sel_valid, o_locked, o_sel} !== {v.grant, v.sv, v.lock, v.sel}) begin
        miscompares++;
        $display("FAIL reset cyc%0d: got grant=%b sel_valid=%b locked=%b sel=%o, want grant=%b sel_valid=%b locked=%b sel=%o",
                 cyc, o_grant, o_sel_valid, o_locked, o_sel, v.grant, v.sv, v.lock, v.sel);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lock_priority();
    vec_t             v;
    int               cyc = 0;
    logic [NP*PW-1:0] d;
    d = pk(0,2,0,2,0);
    push(1'b0, 5'b01010, 5'b01010, 5'b00000, d, 5'b11111, 5'b00010, pk(0,0,1,0,0), 5'b00100, 5'b00000);
    push(1'b0, 5'b01010, 5'b01000, 5'b00000, d, 5'b11111, 5'b00010, pk(0,0,1,0,0), 5'b00100, 5'b00100);
    push(1'b0, 5'b01010, 5'b01000, 5'b00010, d, 5'b11111, 5'b00010, pk(0,0,1,0,0), 5'b00100, 5'b00100);
    push(1'b0, 5'b01000, 5'b01000, 5'b00000, d, 5'b11111, 5'b01000, pk(0,0,3,0,0), 5'b00100, 5'b00000);
    push(1'b0, 5'b01000, 5'b00000, 5'b01000, d, 5'b11111, 5'b01000, pk(0,0,3,0,0), 5'b00100, 5'b00100);
    push(1'b0, '0, '0, '0, '0, 5'b11111, '0, '0, '0, '0);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      reset = v.rst; i_req = v.req; i_head = v.head; i_tail = v.tail; i_dest = v.dest; i_out_on = v.on;
      @(negedge clk);
      vectors++;
      if ({o_grant, o_sel_valid, o_locked, o_sel} !== {v.grant, v.sv, v.lock, v.sel}) begin
        miscompares++;
        $display("FAIL lock_priority cyc%0d: got grant=%b sel_valid=%b locked=%b sel=%o, want grant=%b sel_valid=%b locked=%b sel=%o",
                 cyc, o_grant, o_sel_valid, o_locked, o_sel, v.grant, v.sv, v.lock, v.sel);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    vec_t          v;
    int            cyc = 0;
    int            order[9] = '{0, 1, 4, 0, 1, 4, 0, 1, 4};
    logic [NP-1:0] req;
    for (int k = 0; k < 9; k++) begin
      req = (k < 7) ? 5'b10011 : (k == 7) ? 5'b10010 : 5'b10000;
      push(1'b0, req, req, req, pk(0,0,0,0,0), 5'b11111, NP'(1) << order[k],
           pk(order[k],0,0,0,0), 5'b00001, 5'b00000);
    end
    push(1'b0, '0, '0, '0, '0, 5'b11111, '0, '0, '0, '0);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      reset = v.rst; i_req = v.req; i_head = v.head; i_tail = v.tail; i_dest = v.dest; i_out_on = v.on;
      @(negedge clk);
      vectors++;
      if ({o_grant, o_sel_valid, o_locked, o_sel} !== {v.grant, v.sv, v.lock, v.sel}) begin
        miscompares++;
        $display("FAIL round_robin cyc%0d: got grant=%b sel_valid=%b locked=%b sel=%o, want grant=%b sel_valid=%b locked=%b sel=%o",
                 cyc, o_grant, o_sel_valid, o_locked, o_sel, v.grant, v.sv, v.lock, v.sel);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    vec_t             v;
    int               cyc = 0;
    logic [NP*PW-1:0] d;
    d = pk(0,0,3,0,3);
    push(1'b0, 5'b10100, 5'b10100, 5'b10000, d, 5'b11111, 5'b00100, pk(0,0,0,2,0), 5'b01000, 5'b00000);
    push(1'b0, 5'b10100, 5'b10000, 5'b10000, d, 5'b11111, 5'b00100, pk(0,0,0,2,0), 5'b01000, 5'b01000);
    push(1'b0, 5'b10100, 5'b10000, 5'b10000, d, 5'b10111, 5'b00000, '0,            5'b00000, 5'b01000);
    push(1'b0, 5'b10100, 5'b10000, 5'b10000, d, 5'b10111, 5'b00000, '0,            5'b00000, 5'b01000);
    push(1'b0, 5'b10100, 5'b10000, 5'b10000, d, 5'b11111, 5'b00100, pk(0,0,0,2,0), 5'b01000, 5'b01000);
    push(1'b0, 5'b10100, 5'b10000, 5'b10100, d, 5'b11111, 5'b00100, pk(0,0,0,2,0), 5'b01000, 5'b01000);
    push(1'b0, 5'b10000, 5'b10000, 5'b10000, d, 5'b11111, 5'b10000, pk(0,0,0,4,0), 5'b01000, 5'b00000);
    push(1'b0, '0, '0, '0, '0, 5'b11111, '0, '0, '0, '0);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      reset = v.rst; i_req = v.req; i_head = v.head; i_tail = v.tail; i_dest = v.dest; i_out_on = v.on;
      @(negedge clk);
      vectors++;
      if ({o_grant, o_sel_valid, o_locked, o_sel} !== {v.grant, v.sv, v.lock, v.sel}) begin
        miscompares++;
        $display("FAIL stall cyc%0d: got grant=%b sel_valid=%b locked=%b sel=%o, want grant=%b sel_valid=%b locked=%b sel=%o",
                 cyc, o_grant, o_sel_valid, o_locked, o_sel, v.grant, v.sv, v.lock, v.sel);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_parallel();
    vec_t             v;
    int               cyc = 0;
    logic [NP*PW-1:0] d;
    d = pk(1,2,3,4,0);
    push(1'b0, 5'b11111, 5'b11111, 5'b00000, d, 5'b11111, 5'b11111, pk(4,0,1,2,3), 5'b11111, 5'b00000);
    push(1'b0, 5'b11111, 5'b00000, 5'b11111, d, 5'b11111, 5'b11111, pk(4,0,1,2,3), 5'b11111, 5'b11111);
    push(1'b0, '0, '0, '0, '0, 5'b11111, '0, '0, '0, '0);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      reset = v.rst; i_req = v.req; i_head = v.head; i_tail = v.tail; i_dest = v.dest; i_out_on = v.on;
      @(negedge clk);
      vectors++;
      if ({o_grant, o_sel_valid, o_locked, o_sel} !== {v.grant, v.sv, v.lock, v.sel}) begin
        miscompares++;
        $display("FAIL parallel cyc%0d: got grant=%b sel_valid=%b locked=%b sel=%o, want grant=%b sel_valid=%b locked=%b sel=%o",
                 cyc, o_grant, o_sel_valid, o_locked, o_sel, v.grant, v.sv, v.lock, v.sel);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midpacket();
    vec_t             v;
    int               cyc = 0;
    logic [NP*PW-1:0] d;
    d = pk(1,0,0,1,0);
    push(1'b0, 5'b01000, 5'b01000, 5'b00000, d, 5'b11111, 5'b01000, pk(0,3,0,0,0), 5'b00010, 5'b00000);
    push(1'b1, 5'b01001, 5'b00001, 5'b00001, d, 5'b11111, 5'b00000, '0,            5'b00000, 5'b00000);
    push(1'b0, 5'b01001, 5'b00001, 5'b00001, d, 5'b11111, 5'b00001, pk(0,0,0,0,0), 5'b00010, 5'b00000);
    push(1'b0, '0, '0, '0, '0, 5'b11111, '0, '0, '0, '0);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      reset = v.rst; i_req = v.req; i_head = v.head; i_tail = v.tail; i_dest = v.dest; i_out_on = v.on;
      @(negedge clk);
      vectors++;
      if ({o_grant, o_sel_valid, o_locked, o_sel} !== {v.grant, v.sv, v.lock, v.sel}) begin
        miscompares++;
        $display("FAIL reset_midpacket cyc%0d: got grant=%b sel_valid=%b locked=%b sel=%o, want grant=%b sel_valid=%b locked=%b sel=%o",
                 cyc, o_grant, o_sel_valid, o_locked, o_sel, v.grant, v.sv, v.lock, v.sel);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bad_dest();
    vec_t v;
    int   cyc = 0;
    push(1'b0, 5'b00100, 5'b00100, 5'b00100, pk(0,0,5,0,0), 5'b11111, '0, '0, '0, '0);
    push(1'b0, 5'b00100, 5'b00100, 5'b00100, pk(0,0,6,0,0), 5'b11111, '0, '0, '0, '0);
    push(1'b0, 5'b00100, 5'b00100, 5'b00100, pk(0,0,7,0,0), 5'b11111, '0, '0, '0, '0);
    push(1'b0, 5'b00100, 5'b00000, 5'b00000, pk(0,0,0,0,0), 5'b11111, '0, '0, '0, '0);
    push(1'b0, 5'b00001, 5'b00001, 5'b00001, pk(0,0,0,0,0), 5'b11110, '0, '0, '0, '0);
    push(1'b0, 5'b01101, 5'b01101, 5'b01101, pk(0,0,0,0,0), 5'b11111, 5'b00001, pk(0,0,0,0,0), 5'b00001, 5'b00000);
    push(1'b0, 5'b01100, 5'b01100, 5'b01100, pk(0,0,0,0,0), 5'b11111, 5'b00100, pk(2,0,0,0,0), 5'b00001, 5'b00000);
    push(1'b0, '0, '0, '0, '0, 5'b11111, '0, '0, '0, '0);
    while (sb.size() > 0) begin
      v = sb.pop_front();
      reset = v.rst; i_req = v.req; i_head = v.head; i_tail = v.tail; i_dest = v.dest; i_out_on = v.on;
      @(negedge clk);
      vectors++;
      if ({o_grant, o_sel_valid, o_locked, o_sel} !== {v.grant, v.sv, v.lock, v.sel}) begin
        miscompares++;
        $display("FAIL bad_dest cyc%0d: got grant=%b sel_valid=%b locked=%b sel=%o, want grant=%b sel_valid=%b locked=%b sel=%o",
                 cyc, o_grant, o_sel_valid, o_locked, o_sel, v.grant, v.sv, v.lock, v.sel);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset    = 1'b1;
    i_req    = '0;
    i_head   = '0;
    i_tail   = '0;
    i_dest   = '0;
    i_out_on = '1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lock_priority();
    test_round_robin();
    test_stall();
    test_parallel();
    test_reset_midpacket();
    test_bad_dest();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
